// File: rtl/plugboard_pkg.sv
// Shared definitions for the plugboard mapper: result codes, FSM states and
// one-hot/index conversion helpers (sized for alphabets up to 64 letters).
package plugboard_pkg;

   localparam int unsigned OH_W  = 64;
   localparam int unsigned IDX_W = 6;

   localparam logic [2:0] ERR_OK         = 3'd0;
   localparam logic [2:0] ERR_SELF       = 3'd1;
   localparam logic [2:0] ERR_IN_USE     = 3'd2;
   localparam logic [2:0] ERR_FULL       = 3'd3;
   localparam logic [2:0] ERR_BAD_ONEHOT = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_COMMIT,
      ST_CLEAR
   } state_t;

   function automatic logic [IDX_W-1:0] oh_to_idx(input logic [OH_W-1:0] oh);
      oh_to_idx = '0;
      for (int unsigned i = 0; i < OH_W; i++) begin
         if (oh[i]) oh_to_idx = IDX_W'(i);
      end
   endfunction

   function automatic logic [OH_W-1:0] idx_to_oh(input logic [IDX_W-1:0] idx);
      idx_to_oh      = '0;
      idx_to_oh[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/plugboard_mapper_onehot_check.sv
// Flags a vector that has exactly one bit set.
module onehot_check #(
   parameter int unsigned W = 26
) (
   input  logic [W-1:0] vec,
   output logic         one
);

   assign one = (vec != '0) && ((vec & (vec - W'(1))) == '0);

endmodule

// File: rtl/plugboard_mapper.sv
// Enigma-style plugboard: a reconfigurable letter-swap table with a handshake
// configuration FSM and a fixed one-cycle translation path.
module plugboard_mapper
   import plugboard_pkg::*;
#(
   parameter int unsigned LETTERS   = 26,
   parameter int unsigned MAX_PAIRS = 10
) (
   input  logic                                 CLOCK_50,
   input  logic                                 reset,
   input  logic                                 cfg_valid,
   output logic                                 cfg_ready,
   input  logic                                 cfg_clear,
   input  logic [LETTERS-1:0]                   cfg_a,
   input  logic [LETTERS-1:0]                   cfg_b,
   output logic                                 cfg_done,
   output logic [2:0]                           cfg_err,
   output logic [$clog2(MAX_PAIRS+1)-1:0]       pair_count,
   input  logic                                 in_valid,
   input  logic [LETTERS-1:0]                   in_letter,
   output logic                                 out_valid,
   output logic [LETTERS-1:0]                   out_letter,
   output logic                                 out_err
);

   localparam int unsigned IDXW = $clog2(LETTERS);
   localparam int unsigned CW   = $clog2(MAX_PAIRS+1);

   state_t                  state_q, state_d;
   logic [IDXW-1:0]         map_q [LETTERS];
   logic [IDXW-1:0]         map_d [LETTERS];
   logic [CW-1:0]           pc_q, pc_d;
   logic [IDXW-1:0]         clr_q, clr_d;
   logic [LETTERS-1:0]      a_q, a_d, b_q, b_d;
   logic                    a_ok_q, a_ok_d, b_ok_q, b_ok_d;
   logic                    done_q, done_d;
   logic [2:0]              err_q, err_d;
   logic                    out_valid_q, out_valid_d;
   logic [LETTERS-1:0]      out_letter_q, out_letter_d;
   logic                    out_err_q, out_err_d;

   logic                    a_ok, b_ok, in_ok;
   logic [IDXW-1:0]         a_idx, b_idx, in_idx;
   logic [2:0]              code;

   onehot_check #(.W(LETTERS)) u_chk_a  (.vec(cfg_a),     .one(a_ok));
   onehot_check #(.W(LETTERS)) u_chk_b  (.vec(cfg_b),     .one(b_ok));
   onehot_check #(.W(LETTERS)) u_chk_in (.vec(in_letter), .one(in_ok));

   assign a_idx  = IDXW'(oh_to_idx(OH_W'(a_q)));
   assign b_idx  = IDXW'(oh_to_idx(OH_W'(b_q)));
   assign in_idx = IDXW'(oh_to_idx(OH_W'(in_letter)));

   // Translation reads map_q, i.e. the table as it stood before this edge's write.
   always_comb begin
      out_valid_d  = in_valid;
      out_err_d    = in_valid & ~in_ok;
      out_letter_d = in_letter;
      if (in_ok && state_q != ST_CLEAR) begin
         out_letter_d = LETTERS'(idx_to_oh(IDX_W'(map_q[in_idx])));
      end
   end

   always_comb begin
      state_d   = state_q;
      map_d     = map_q;
      pc_d      = pc_q;
      clr_d     = clr_q;
      a_d       = a_q;
      b_d       = b_q;
      a_ok_d    = a_ok_q;
      b_ok_d    = b_ok_q;
      done_d    = 1'b0;
      err_d     = ERR_OK;
      cfg_ready = 1'b0;
      code      = ERR_OK;

      if (!a_ok_q || !b_ok_q)                                 code = ERR_BAD_ONEHOT;
      else if (a_q == b_q)                                    code = ERR_SELF;
      else if (map_q[a_idx] != a_idx || map_q[b_idx] != b_idx) code = ERR_IN_USE;
      else if (pc_q == CW'(MAX_PAIRS))                        code = ERR_FULL;

      case (state_q)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               if (cfg_clear) begin
                  state_d = ST_CLEAR;
                  clr_d   = '0;
               end else begin
                  state_d = ST_CHECK;
                  a_d     = cfg_a;
                  b_d     = cfg_b;
                  a_ok_d  = a_ok;
                  b_ok_d  = b_ok;
               end
            end
         end
         ST_CHECK: begin
            if (code != ERR_OK) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               err_d   = code;
            end else begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            map_d[a_idx] = b_idx;
            map_d[b_idx] = a_idx;
            pc_d         = pc_q + CW'(1);
            done_d       = 1'b1;
            state_d      = ST_IDLE;
         end
         ST_CLEAR: begin
            map_d[clr_q] = clr_q;
            if (clr_q == IDXW'(LETTERS-1)) begin
               pc_d    = '0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               clr_d = clr_q + IDXW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= ST_IDLE;
         for (int unsigned i = 0; i < LETTERS; i++) map_q[i] <= IDXW'(i);
         pc_q         <= '0;
         clr_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         a_ok_q       <= 1'b0;
         b_ok_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= ERR_OK;
         out_valid_q  <= 1'b0;
         out_letter_q <= '0;
         out_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         map_q        <= map_d;
         pc_q         <= pc_d;
         clr_q        <= clr_d;
         a_q          <= a_d;
         b_q          <= b_d;
         a_ok_q       <= a_ok_d;
         b_ok_q       <= b_ok_d;
         done_q       <= done_d;
         err_q        <= err_d;
         out_valid_q  <= out_valid_d;
         out_letter_q <= out_letter_d;
         out_err_q    <= out_err_d;
      end
   end

   assign cfg_done   = done_q;
   assign cfg_err    = err_q;
   assign pair_count = pc_q;
   assign out_valid  = out_valid_q;
   assign out_letter = out_letter_q;
   assign out_err    = out_err_q;

endmodule

// File: tb/tb_plugboard_mapper.sv
// Randomized self-checking bench for plugboard_mapper against a partner-array model.
module tb_plugboard_mapper;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_valid = 1'b0, cfg_clear = 1'b0;
   logic        cfg_ready, cfg_done;
   logic [25:0] cfg_a = '0, cfg_b = '0;
   logic [2:0]  cfg_err;
   logic [3:0]  pair_count;
   logic        in_valid = 1'b0;
   logic [25:0] in_letter = '0;
   logic        out_valid, out_err;
   logic [25:0] out_letter;

   plugboard_mapper #(.LETTERS(26), .MAX_PAIRS(10)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_clear(cfg_clear),
      .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_done(cfg_done), .cfg_err(cfg_err),
      .pair_count(pair_count),
      .in_valid(in_valid), .in_letter(in_letter),
      .out_valid(out_valid), .out_letter(out_letter), .out_err(out_err)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int ref_map [26];
   int ref_cnt;
   bit clearing = 1'b0;
   bit fix_mode = 1'b0;
   logic [25:0] fix_letter = '0;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int oh_idx(input logic [25:0] v);
      for (int i = 0; i < 26; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [25:0] letter(input int i);
      logic [25:0] one;
      one = 26'd1;
      return one << i;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 26; i++) ref_map[i] = i;
      ref_cnt = 0;
   endtask

   function automatic int model_err(input logic [25:0] a, input logic [25:0] b);
      int ia, ib;
      if ($countones(a) != 1 || $countones(b) != 1) return 4;
      if (a == b) return 1;
      ia = oh_idx(a);
      ib = oh_idx(b);
      if (ref_map[ia] != ia || ref_map[ib] != ib) return 2;
      if (ref_cnt == 10) return 3;
      return 0;
   endfunction

   // One clock: drive a translation input, predict from the pre-edge model, check after.
   task automatic step();
      logic [25:0] exp_l;
      logic        exp_v, exp_e;
      if (fix_mode) begin
         in_valid  = 1'b1;
         in_letter = fix_letter;
      end else begin
         in_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) in_letter = 26'($urandom);
         else                           in_letter = letter($urandom_range(0, 25));
      end
      exp_v = in_valid;
      exp_e = ($countones(in_letter) != 1);
      exp_l = in_letter;
      if (!exp_e && !clearing) exp_l = letter(ref_map[oh_idx(in_letter)]);
      @(posedge CLOCK_50);
      #1;
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
         chk("out_letter", 32'(out_letter), 32'(exp_l));
         chk("out_err", 32'(out_err), 32'(exp_e));
      end
   endtask

   task automatic do_req(input bit clr, input logic [25:0] a, input logic [25:0] b);
      int exp_err, lat, lowcnt;
      bit got;
      chk("ready_idle", 32'(cfg_ready), 32'd1);
      exp_err   = clr ? 0 : model_err(a, b);
      cfg_valid = 1'b1;
      cfg_clear = clr;
      cfg_a     = a;
      cfg_b     = b;
      step();
      lat    = 1;
      lowcnt = cfg_ready ? 0 : 1;
      chk("ready_busy", 32'(cfg_ready), 32'd0);
      cfg_valid = 1'b0;
      cfg_clear = 1'($urandom);
      cfg_a     = 26'($urandom);
      cfg_b     = 26'($urandom);
      if (clr) clearing = 1'b1;
      got = 1'b0;
      while (!got && lat < 60) begin
         step();
         lat++;
         if (cfg_done) got = 1'b1;
         else if (!cfg_ready) lowcnt++;
      end
      clearing = 1'b0;
      chk("done_seen", 32'(got), 32'd1);
      chk("cfg_err", 32'(cfg_err), 32'(exp_err));
      chk("latency", 32'(lat), clr ? 32'd27 : (exp_err == 0 ? 32'd3 : 32'd2));
      if (clr) begin
         chk("ready_low", 32'(lowcnt), 32'd26);
         model_reset();
      end else if (exp_err == 0) begin
         ref_map[oh_idx(a)] = oh_idx(b);
         ref_map[oh_idx(b)] = oh_idx(a);
         ref_cnt++;
      end
      chk("pair_count", 32'(pair_count), 32'(ref_cnt));
      step();
      chk("done_pulse", 32'(cfg_done), 32'd0);
   endtask

   task automatic check_identity();
      fix_mode = 1'b1;
      for (int i = 0; i < 26; i++) begin
         fix_letter = letter(i);
         step();
      end
      fix_mode = 1'b0;
   endtask

   task automatic rand_pair(output logic [25:0] a, output logic [25:0] b);
      a = letter($urandom_range(0, 25));
      b = letter($urandom_range(0, 25));
      if ($urandom_range(0, 9) == 0) a = 26'($urandom);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [25:0] a, b;
      int iter, f0, f1;
      model_reset();
      repeat (2) @(posedge CLOCK_50);
      #1;
      chk("rst_count", 32'(pair_count), 32'd0);
      chk("rst_done", 32'(cfg_done), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_letter", 32'(out_letter), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      reset = 1'b0;

      // A/B pair and basic translations
      do_req(1'b0, letter(0), letter(1));
      fix_mode = 1'b1;
      fix_letter = letter(0); step();
      fix_letter = letter(1); step();
      fix_letter = letter(2); step();
      fix_mode = 1'b0;

      // Rejections
      do_req(1'b0, letter(0), letter(2));
      do_req(1'b0, letter(3), letter(3));
      do_req(1'b0, 26'h3, letter(5));
      do_req(1'b0, letter(7), 26'h0);

      // Fill to capacity with random requests, then overflow
      iter = 0;
      while (ref_cnt < 10 && iter < 400) begin
         rand_pair(a, b);
         do_req(1'b0, a, b);
         iter++;
      end
      chk("filled", 32'(ref_cnt), 32'd10);
      f0 = -1; f1 = -1;
      for (int i = 0; i < 26; i++) begin
         if (ref_map[i] == i) begin
            if (f0 < 0) f0 = i;
            else if (f1 < 0) f1 = i;
         end
      end
      do_req(1'b0, letter(f0), letter(f1));
      chk("full_count", 32'(pair_count), 32'd10);
      repeat (20) step();

      // Clear from full, then clear again with 3 pairs installed
      do_req(1'b1, '0, '0);
      check_identity();
      do_req(1'b0, letter(4), letter(9));
      do_req(1'b0, letter(10), letter(20));
      do_req(1'b0, letter(12), letter(17));
      repeat (10) step();
      do_req(1'b1, letter(4), letter(9));
      check_identity();

      // Translate A continuously across an A/B commit, then Z
      fix_mode = 1'b1;
      fix_letter = letter(0);
      do_req(1'b0, letter(0), letter(1));
      step();
      fix_letter = letter(25);
      step();
      fix_mode = 1'b0;

      // Random mixed traffic
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 9) == 0) do_req(1'b1, '0, '0);
         else begin
            rand_pair(a, b);
            do_req(1'b0, a, b);
         end
      end

      // Reset in the middle of a clear
      do_req(1'b1, '0, '0);
      do_req(1'b0, letter(2), letter(8));
      do_req(1'b0, letter(6), letter(24));
      cfg_valid = 1'b1;
      cfg_clear = 1'b1;
      step();
      cfg_valid = 1'b0;
      cfg_clear = 1'b0;
      clearing  = 1'b1;
      repeat (10) begin
         step();
         chk("midclear_done", 32'(cfg_done), 32'd0);
      end
      reset = 1'b1;
      @(posedge CLOCK_50);
      #1;
      reset    = 1'b0;
      clearing = 1'b0;
      model_reset();
      chk("abort_done", 32'(cfg_done), 32'd0);
      chk("abort_count", 32'(pair_count), 32'd0);
      chk("abort_ready", 32'(cfg_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      step();
      chk("abort_done_after", 32'(cfg_done), 32'd0);
      check_identity();
      do_req(1'b0, letter(2), letter(3));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/plugboard_mapper.md
PLUGBOARD_MAPPER -- requirements
Module: plugboard_mapper

Interface
REQ-001 SHALL have parameter LETTERS, default 26, alphabet size and one-hot letter width.
REQ-002 SHALL have parameter MAX_PAIRS, default 10, maximum simultaneous swap pairs.
REQ-003 SHALL have port CLOCK_50  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_valid  input  1  configuration request present.
REQ-006 SHALL have port cfg_ready  output  1  request accepted this cycle when high with cfg_valid.
REQ-007 SHALL have port cfg_clear  input  1  with cfg_valid: clear all pairs, ignoring cfg_a/cfg_b.
REQ-008 SHALL have port cfg_a  input  LETTERS  first letter of pair, one-hot.
REQ-009 SHALL have port cfg_b  input  LETTERS  second letter of pair, one-hot.
REQ-010 SHALL have port cfg_done  output  1  one-cycle pulse when a request completes.
REQ-011 SHALL have port cfg_err  output  3  result code, valid while cfg_done is high.
REQ-012 SHALL have port pair_count  output  clog2(MAX_PAIRS+1)  number of installed pairs.
REQ-013 SHALL have port in_valid  input  1  letter to translate.
REQ-014 SHALL have port in_letter  input  LETTERS  letter to translate, one-hot.
REQ-015 SHALL have port out_valid  output  1  translated letter present.
REQ-016 SHALL have port out_letter  output  LETTERS  translated letter, one-hot.
REQ-017 SHALL have port out_err  output  1  in_letter was not exactly one-hot.

Function
REQ-018 SHALL hold a LETTERS-entry table of encoded partner indices; an entry equal to its own index means unpaired.
REQ-019 SHALL run the FSM IDLE -> CHECK -> COMMIT -> IDLE for pair requests and IDLE -> CLEAR -> IDLE for clear requests.
REQ-020 IDLE SHALL drive cfg_ready=1; the request SHALL be captured on cfg_valid&cfg_ready; cfg_ready SHALL be 0 in every other state.
REQ-021 CHECK SHALL take one cycle and evaluate, in priority order: 4=BAD_ONEHOT (cfg_a or cfg_b not one-hot), 1=SELF (a==b), 2=IN_USE (either letter already paired), 3=FULL (pair_count==MAX_PAIRS), else 0=OK.
REQ-022 On a nonzero code, the FSM SHALL return to IDLE with cfg_done=1 and that code, leaving the table unchanged.
REQ-023 COMMIT SHALL write a->b and b->a in one cycle, increment pair_count, and pulse cfg_done with cfg_err=0.
REQ-024 CLEAR SHALL restore one entry per cycle to identity, indices 0..LETTERS-1, taking LETTERS cycles; it SHALL zero pair_count on the last cycle and pulse cfg_done with cfg_err=0.
REQ-025 Translation SHALL have a fixed 1-cycle latency: out_valid(t+1)=in_valid(t), and out_letter SHALL be the one-hot partner of in_letter.
REQ-026 Translation SHALL accept input every cycle, independent of the FSM, and SHALL use the table value before any write in the same cycle.
REQ-027 During CLEAR, translation SHALL return in_letter unchanged.
REQ-028 A non-one-hot in_letter SHALL produce out_letter=in_letter and out_err=1 with out_valid.
REQ-029 cfg_a/cfg_b SHALL be sampled only at acceptance; later input changes SHALL have no effect on the request in progress.

Reset
REQ-030 reset SHALL put the FSM in IDLE, set every table entry to identity in one cycle, and clear pair_count, cfg_done, cfg_err, out_valid, out_letter and out_err to 0.
REQ-031 reset asserted mid-CHECK, COMMIT or CLEAR SHALL abort the request without a cfg_done pulse; cfg_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-032 Package plugboard_pkg SHALL hold the error-code constants, the FSM state enum, and the onehot-to-index and index-to-onehot functions.
REQ-033 SHALL contain one sub-module, onehot_check, which flags "exactly one bit set" and is instantiated for cfg_a, cfg_b and in_letter.

Verification
REQ-034 Reset, then pair A(bit0)/B(bit1) -> cfg_done after 3 cycles with err=0 and pair_count=1; in A -> out B and in B -> out A next cycle; in C -> out C.
REQ-035 Pair A/C after A/B -> err=2, table unchanged; pair D/D -> err=1; cfg_a=0x3 -> err=4.
REQ-036 Install 10 valid pairs, then an 11th -> err=3 and pair_count stays 10.
REQ-037 Clear with 3 pairs installed -> cfg_ready low for 26+ cycles, cfg_done err=0, pair_count=0; all letters map to themselves after.
REQ-038 Translate A every cycle while committing A/B -> the output is A until the cycle after COMMIT, then B; translate bit25 (Z) -> out bit25.
REQ-039 Assert reset during CLEAR -> no cfg_done pulse, identity table, pair_count=0, cfg_ready=1 on the next cycle.
